des_region_scheduler: RTL and testbench
=======================================

// Module: des_region_scheduler
// PURPOSE
//  Host-side driver for one des_block. Sweeps a range of counter regions:
//  start each region, wait for done, add the block's 48-bit counter into a wide total, restart the block.
//  In test mode it instead single-steps the block's pipeline and hands each ciphertext to the host
//  over a valid/ready handshake. Sits between the CPU register interface and des_block.
// PARAMETERS
//  REGION_FIRST  16'h0  first region_select value of a sweep
//  REGION_COUNT  16     regions per sweep (1..65536); region = REGION_FIRST+idx, 16-bit wrap
//  CNT_W         48     width of blk_counter
//  ACC_W         64     total accumulator width; elaboration error if ACC_W < CNT_W+$clog2(REGION_COUNT)
// PORTS
//  clk                 in   1      clock
//  rst_n               in   1      reset, asynchronous, active low
//  host_start          in   1      1-cycle request: begin sweep (or test run if host_test_mode)
//  host_test_mode      in   1      sampled with host_start
//  host_test_steps     in   16     ciphertexts to capture in test mode (0 treated as 1); sampled with host_start
//  host_abort          in   1      stop immediately, restart block
//  host_busy           out  1      operation in progress
//  host_done           out  1      sticky: last op completed normally; cleared on next accepted host_start
//  host_total          out  ACC_W  sum of blk_counter over completed regions
//  host_regions_done   out  17     regions completed in current/last sweep
//  host_ct_valid       out  1      test ciphertext available
//  host_ct_ready       in   1      host accepts ciphertext
//  host_ct_data        out  64     ciphertext (stable while host_ct_valid)
//  blk_start           out  1      -> des_block.start (1-cycle pulse)
//  blk_restart         out  1      -> des_block.restart_block (1-cycle pulse)
//  blk_test_enabled    out  1      -> des_block.test_enabled
//  blk_test_advance    out  1      -> des_block.test_advance (1-cycle pulse)
//  blk_region_select   out  16     -> des_block.region_select
//  blk_done            in   1      <- des_block.done (level, held until restart)
//  blk_counter         in   CNT_W  <- des_block.counter
//  blk_test_data_valid in   1      <- des_block.test_data_valid
//  blk_ciphertext      in   64     <- des_block.ciphertext_out
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except blk_region_select=REGION_FIRST; counters/total cleared.
//  FSM (all outputs registered or decoded from state; pulses last exactly one cycle):
//   IDLE: host_start & !host_abort -> clear total, regions_done, idx, host_done; host_busy=1;
//         -> LAUNCH (normal) or T_LAUNCH (test). host_start while busy: ignored.
//   LAUNCH: blk_start=1, region=REGION_FIRST+idx -> RUN.
//   RUN: wait blk_done=1 -> COLLECT.
//   COLLECT: total += zero-extended blk_counter; regions_done++ -> CLEAR.
//   CLEAR: blk_restart=1 -> idx==REGION_COUNT-1 ? FIN : (idx++, LAUNCH).
//      Block is back in init the cycle after CLEAR, so LAUNCH follows directly.
//   FIN: host_busy=0, host_done=1 -> IDLE.
//   T_LAUNCH: blk_test_enabled=1, blk_start=1 -> T_WAIT.
//   T_WAIT: blk_test_enabled=1; blk_test_data_valid=1 -> capture blk_ciphertext, T_PRESENT.
//   T_PRESENT: host_ct_valid=1; on valid&ready: steps-- ; steps==0 -> T_EXIT else T_ADVANCE.
//   T_ADVANCE: blk_test_advance=1 -> T_WAIT. Block is in test_run, valid=0 the next cycle,
//      so there is no false capture.
//   T_EXIT: blk_test_enabled=0, blk_restart=1 -> FIN.
//  Latency: normal sweep = REGION_COUNT*(block run time + 4) cycles; test, first ct: T_WAIT + 1.
//  host_abort (any state, highest priority): next cycle blk_restart=1, blk_test_enabled=0,
//   host_ct_valid=0, host_busy=0, host_done stays 0, total/regions_done hold partial values -> IDLE.
//   host_abort in IDLE with host_start: abort wins, start dropped.
//  region_select wraps modulo 2^16. No overflow is possible given the ACC_W check.
//  rst_n mid-operation: everything returns to reset values asynchronously. The block shares rst_n.
// STRUCTURE
//  des_pkg: state localparams, CNT_W/region width constants, shared with des_block users.
//  Single module; no sub-module (accumulator and FSM are tightly coupled).
// TESTING
//  REGION_COUNT=4, model block done after 10 cycles with counter=5,7,9,11
//   -> host_total=32, regions_done=4, 4 start/restart pulse pairs, region 0..3, host_done=1.
//  Counter=2^48-1 for all 16 regions -> host_total=16*(2^48-1), no wrap.
//  Test mode, steps=3, host_ct_ready held low 5 cycles on 2nd ct -> 3 captures, data stable while stalled,
//   2 advance pulses, restart at exit.
//  host_abort during RUN of region 2 -> restart next cycle, busy=0, done=0, regions_done=2; new start works.
//  host_start while busy, and start+abort in IDLE -> both ignored; steps=0 -> exactly 1 ct.
//  rst_n low mid-sweep (async, between edges) -> outputs at reset values before next clk edge.

Source files
------------

// File: rtl/des_pkg.sv
// Shared constants for des_block users: scheduler state encoding and datapath widths.
package des_pkg;

    localparam int REGION_W  = 16;
    localparam int CT_W      = 64;
    localparam int STEPS_W   = 16;
    localparam int RDONE_W   = 17;
    localparam int DEF_CNT_W = 48;
    localparam int ST_W      = 4;

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LAUNCH    = 4'd1;
    localparam logic [3:0] S_RUN       = 4'd2;
    localparam logic [3:0] S_COLLECT   = 4'd3;
    localparam logic [3:0] S_CLEAR     = 4'd4;
    localparam logic [3:0] S_FIN       = 4'd5;
    localparam logic [3:0] S_T_LAUNCH  = 4'd6;
    localparam logic [3:0] S_T_WAIT    = 4'd7;
    localparam logic [3:0] S_T_PRESENT = 4'd8;
    localparam logic [3:0] S_T_ADVANCE = 4'd9;
    localparam logic [3:0] S_T_EXIT    = 4'd10;

    function automatic logic is_test_state(input logic [3:0] s);
        return (s == S_T_LAUNCH) || (s == S_T_WAIT) || (s == S_T_PRESENT) || (s == S_T_ADVANCE);
    endfunction

endpackage

// File: rtl/des_region_scheduler.sv
// Host-side driver for one des_block: sweeps counter regions accumulating the block's counter,
// or single-steps the block in test mode and hands ciphertexts to the host.
module des_region_scheduler
    import des_pkg::*;
#(
    parameter logic [15:0] REGION_FIRST = 16'h0,
    parameter int unsigned REGION_COUNT = 16,
    parameter int          CNT_W        = DEF_CNT_W,
    parameter int          ACC_W        = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                host_start,
    input  logic                host_test_mode,
    input  logic [STEPS_W-1:0]  host_test_steps,
    input  logic                host_abort,
    output logic                host_busy,
    output logic                host_done,
    output logic [ACC_W-1:0]    host_total,
    output logic [RDONE_W-1:0]  host_regions_done,
    output logic                host_ct_valid,
    input  logic                host_ct_ready,
    output logic [CT_W-1:0]     host_ct_data,
    output logic                blk_start,
    output logic                blk_restart,
    output logic                blk_test_enabled,
    output logic                blk_test_advance,
    output logic [REGION_W-1:0] blk_region_select,
    input  logic                blk_done,
    input  logic [CNT_W-1:0]    blk_counter,
    input  logic                blk_test_data_valid,
    input  logic [CT_W-1:0]     blk_ciphertext
);

    if (ACC_W < CNT_W + $clog2(REGION_COUNT)) begin : g_acc_width_check
        $error("des_region_scheduler: ACC_W too narrow for CNT_W and REGION_COUNT");
    end

    localparam logic [RDONE_W-1:0] IDX_LAST = RDONE_W'(REGION_COUNT - 1);

    logic [ST_W-1:0]     state_q, state_d;
    logic [RDONE_W-1:0]  idx_q, idx_d;
    logic [ACC_W-1:0]    total_q, total_d;
    logic [RDONE_W-1:0]  rdone_q, rdone_d;
    logic [STEPS_W-1:0]  steps_q, steps_d;
    logic [CT_W-1:0]     ct_q, ct_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                start_q, start_d;
    logic                restart_q, restart_d;
    logic                test_en_q, test_en_d;
    logic                adv_q, adv_d;
    logic                ctv_q, ctv_d;
    logic [REGION_W-1:0] region_q, region_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        total_d   = total_q;
        rdone_d   = rdone_q;
        steps_d   = steps_q;
        ct_d      = ct_q;
        done_d    = done_q;
        region_d  = region_q;
        restart_d = 1'b0;

        // Abort overrides everything, including a simultaneous start in IDLE.
        if (host_abort) begin
            state_d   = S_IDLE;
            restart_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host_start) begin
                        total_d = '0;
                        rdone_d = '0;
                        idx_d   = '0;
                        done_d  = 1'b0;
                        steps_d = (host_test_steps == '0) ? STEPS_W'(1) : host_test_steps;
                        state_d = host_test_mode ? S_T_LAUNCH : S_LAUNCH;
                    end
                end
                S_LAUNCH:  state_d = S_RUN;
                S_RUN:     if (blk_done) state_d = S_COLLECT;
                S_COLLECT: begin
                    total_d = total_q + ACC_W'(blk_counter);
                    rdone_d = rdone_q + RDONE_W'(1);
                    state_d = S_CLEAR;
                end
                S_CLEAR: begin
                    if (idx_q == IDX_LAST) begin
                        state_d = S_FIN;
                    end else begin
                        idx_d   = idx_q + RDONE_W'(1);
                        state_d = S_LAUNCH;
                    end
                end
                S_FIN:      state_d = S_IDLE;
                S_T_LAUNCH: state_d = S_T_WAIT;
                S_T_WAIT: begin
                    if (blk_test_data_valid) begin
                        ct_d    = blk_ciphertext;
                        state_d = S_T_PRESENT;
                    end
                end
                S_T_PRESENT: begin
                    if (host_ct_ready) begin
                        steps_d = steps_q - STEPS_W'(1);
                        state_d = (steps_q == STEPS_W'(1)) ? S_T_EXIT : S_T_ADVANCE;
                    end
                end
                S_T_ADVANCE: state_d = S_T_WAIT;
                S_T_EXIT:    state_d = S_FIN;
                default:     state_d = S_IDLE;
            endcase
        end

        // Outputs are registered from the next state so each pulse spans exactly its state.
        start_d   = (state_d == S_LAUNCH) || (state_d == S_T_LAUNCH);
        restart_d = restart_d || (state_d == S_CLEAR) || (state_d == S_T_EXIT);
        test_en_d = is_test_state(state_d);
        adv_d     = (state_d == S_T_ADVANCE);
        ctv_d     = (state_d == S_T_PRESENT);
        busy_d    = !((state_d == S_IDLE) || (state_d == S_FIN));
        if (state_d == S_FIN) done_d = 1'b1;
        if (state_d == S_LAUNCH) region_d = REGION_FIRST + idx_d[REGION_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            total_q   <= '0;
            rdone_q   <= '0;
            steps_q   <= '0;
            ct_q      <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            restart_q <= 1'b0;
            test_en_q <= 1'b0;
            adv_q     <= 1'b0;
            ctv_q     <= 1'b0;
            region_q  <= REGION_FIRST;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            total_q   <= total_d;
            rdone_q   <= rdone_d;
            steps_q   <= steps_d;
            ct_q      <= ct_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            restart_q <= restart_d;
            test_en_q <= test_en_d;
            adv_q     <= adv_d;
            ctv_q     <= ctv_d;
            region_q  <= region_d;
        end
    end

    assign host_busy         = busy_q;
    assign host_done         = done_q;
    assign host_total        = total_q;
    assign host_regions_done = rdone_q;
    assign host_ct_valid     = ctv_q;
    assign host_ct_data      = ct_q;
    assign blk_start         = start_q;
    assign blk_restart       = restart_q;
    assign blk_test_enabled  = test_en_q;
    assign blk_test_advance  = adv_q;
    assign blk_region_select = region_q;

endmodule

// File: tb/tb_des_region_scheduler.sv
// Directed bench: two schedulers (4 regions from 0, 16 regions wrapping from 0xFFF8) on behavioural des_block models.
module tb_des_region_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        h_start [2];
    logic        h_tm    [2];
    logic [15:0] h_steps [2];
    logic        h_abort [2];
    logic        h_busy  [2];
    logic        h_done  [2];
    logic [63:0] h_total [2];
    logic [16:0] h_rdone [2];
    logic        h_ctv   [2];
    logic        h_ready [2];
    logic [63:0] h_ct    [2];
    logic        b_start [2];
    logic        b_rst   [2];
    logic        b_ten   [2];
    logic        b_adv   [2];
    logic [15:0] b_region[2];
    logic        m_done  [2];
    logic [47:0] m_cnt   [2];
    logic        t_valid [2];
    logic [63:0] b_ct    [2];

    des_region_scheduler #(.REGION_FIRST(16'h0000), .REGION_COUNT(4), .CNT_W(48), .ACC_W(64)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .host_start(h_start[0]), .host_test_mode(h_tm[0]), .host_test_steps(h_steps[0]),
        .host_abort(h_abort[0]), .host_busy(h_busy[0]), .host_done(h_done[0]),
        .host_total(h_total[0]), .host_regions_done(h_rdone[0]), .host_ct_valid(h_ctv[0]),
        .host_ct_ready(h_ready[0]), .host_ct_data(h_ct[0]),
        .blk_start(b_start[0]), .blk_restart(b_rst[0]), .blk_test_enabled(b_ten[0]),
        .blk_test_advance(b_adv[0]), .blk_region_select(b_region[0]), .blk_done(m_done[0]),
        .blk_counter(m_cnt[0]), .blk_test_data_valid(t_valid[0]), .blk_ciphertext(b_ct[0])
    );

    des_region_scheduler #(.REGION_FIRST(16'hFFF8), .REGION_COUNT(16), .CNT_W(48), .ACC_W(64)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .host_start(h_start[1]), .host_test_mode(h_tm[1]), .host_test_steps(h_steps[1]),
        .host_abort(h_abort[1]), .host_busy(h_busy[1]), .host_done(h_done[1]),
        .host_total(h_total[1]), .host_regions_done(h_rdone[1]), .host_ct_valid(h_ctv[1]),
        .host_ct_ready(h_ready[1]), .host_ct_data(h_ct[1]),
        .blk_start(b_start[1]), .blk_restart(b_rst[1]), .blk_test_enabled(b_ten[1]),
        .blk_test_advance(b_adv[1]), .blk_region_select(b_region[1]), .blk_done(m_done[1]),
        .blk_counter(m_cnt[1]), .blk_test_data_valid(t_valid[1]), .blk_ciphertext(b_ct[1])
    );

    // Block model: done 10 cycles after start (counter 5+2*region or all-ones),
    // test ciphertext 3 cycles after start and 2 cycles after each advance.
    int          run_cnt [2];
    int          t_cnt   [2];
    logic [15:0] seq     [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                run_cnt[i] <= 0; t_cnt[i] <= 0; seq[i] <= '0;
                m_done[i] <= 1'b0; m_cnt[i] <= '0; t_valid[i] <= 1'b0;
            end else if (b_rst[i]) begin
                run_cnt[i] <= 0; t_cnt[i] <= 0; seq[i] <= '0;
                m_done[i] <= 1'b0; t_valid[i] <= 1'b0;
            end else if (b_start[i]) begin
                if (b_ten[i]) t_cnt[i] <= 3;
                else          run_cnt[i] <= 10;
            end else begin
                if (run_cnt[i] > 0) begin
                    run_cnt[i] <= run_cnt[i] - 1;
                    if (run_cnt[i] == 1) begin
                        m_done[i] <= 1'b1;
                        m_cnt[i]  <= (i == 0) ? 48'd5 + 48'(2 * b_region[i]) : {48{1'b1}};
                    end
                end
                if (b_adv[i]) begin
                    t_valid[i] <= 1'b0; t_cnt[i] <= 2; seq[i] <= seq[i] + 16'd1;
                end else if (t_cnt[i] > 0) begin
                    t_cnt[i] <= t_cnt[i] - 1;
                    if (t_cnt[i] == 1) t_valid[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) b_ct[i] = {48'hC0DE_0000_0000, seq[i]};
    end

    int          n_start [2];
    int          n_rst   [2];
    int          n_adv   [2];
    int          n_acc   [2];
    logic [15:0] reg_log [2][32];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (b_start[i]) begin
                reg_log[i][n_start[i] % 32] <= b_region[i];
                n_start[i] <= n_start[i] + 1;
            end
            if (b_rst[i]) n_rst[i] <= n_rst[i] + 1;
            if (b_adv[i]) n_adv[i] <= n_adv[i] + 1;
            if (h_ctv[i] && h_ready[i]) n_acc[i] <= n_acc[i] + 1;
        end
    end

    int nassert = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input int i, input logic tm, input logic [15:0] st);
        @(negedge clk);
        h_start[i] = 1'b1; h_tm[i] = tm; h_steps[i] = st;
        @(negedge clk);
        h_start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int lim, input string tag);
        int n;
        logic got;
        n = 0;
        while (!h_done[i] && n < lim) begin
            @(negedge clk);
            n++;
        end
        got = h_done[i];
        chk(tag, 64'(got), 64'd1);
    endtask

    task automatic wait_ctv(input int i, input int lim, input string tag);
        int n;
        logic got;
        n = 0;
        while (!h_ctv[i] && n < lim) begin
            @(negedge clk);
            n++;
        end
        got = h_ctv[i];
        chk(tag, 64'(got), 64'd1);
    endtask

    initial begin
        int bs, br, ba, bv, n;
        logic got;
        for (int i = 0; i < 2; i++) begin
            h_start[i] = 1'b0; h_tm[i] = 1'b0; h_steps[i] = '0; h_abort[i] = 1'b0; h_ready[i] = 1'b0;
        end
        repeat (2) @(negedge clk);

        chk("rst_busy",   64'(h_busy[0]), 64'd0);
        chk("rst_done",   64'(h_done[0]), 64'd0);
        chk("rst_total",  h_total[0], 64'd0);
        chk("rst_rdone",  64'(h_rdone[0]), 64'd0);
        chk("rst_start",  64'(b_start[0]), 64'd0);
        chk("rst_restart",64'(b_rst[0]), 64'd0);
        chk("rst_ten",    64'(b_ten[0]), 64'd0);
        chk("rst_ctv",    64'(h_ctv[0]), 64'd0);
        chk("rst_region0",64'(b_region[0]), 64'h0000);
        chk("rst_region1",64'(b_region[1]), 64'hFFF8);
        rst_n = 1'b1;
        @(negedge clk);

        // Normal sweep, 4 regions; a start while busy must be ignored.
        bs = n_start[0]; br = n_rst[0];
        pulse_start(0, 1'b0, 16'd0);
        chk("busy_after_start", 64'(h_busy[0]), 64'd1);
        @(negedge clk);
        pulse_start(0, 1'b0, 16'd0);
        wait_done(0, 300, "sweep4_done_tmo");
        chk("sweep4_total",   h_total[0], 64'd32);
        chk("sweep4_rdone",   64'(h_rdone[0]), 64'd4);
        chk("sweep4_starts",  64'(n_start[0] - bs), 64'd4);
        chk("sweep4_restarts",64'(n_rst[0] - br), 64'd4);
        chk("sweep4_busy",    64'(h_busy[0]), 64'd0);
        for (int k = 0; k < 4; k++) chk("sweep4_region", 64'(reg_log[0][(bs + k) % 32]), 64'(k));
        @(negedge clk);
        chk("done_sticky", 64'(h_done[0]), 64'd1);

        // 16 regions of max counter, region_select wraps past 0xFFFF.
        bs = n_start[1];
        pulse_start(1, 1'b0, 16'd0);
        wait_done(1, 400, "sweep16_done_tmo");
        chk("sweep16_total", h_total[1], 64'h000F_FFFF_FFFF_FFF0);
        chk("sweep16_rdone", 64'(h_rdone[1]), 64'd16);
        chk("sweep16_first", 64'(reg_log[1][bs % 32]), 64'hFFF8);
        chk("sweep16_last",  64'(reg_log[1][(bs + 15) % 32]), 64'h0007);

        // Test mode, 3 ciphertexts, host stalls 5 cycles on the second.
        bs = n_start[0]; br = n_rst[0]; ba = n_acc[0]; bv = n_adv[0];
        pulse_start(0, 1'b1, 16'd3);
        for (int k = 0; k < 3; k++) begin
            wait_ctv(0, 50, "ct_valid_tmo");
            chk("ct_data", h_ct[0], {48'hC0DE_0000_0000, 16'(k)});
            if (k == 1) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(h_ctv[0]), 64'd1);
                    chk("stall_data", h_ct[0], 64'hC0DE_0000_0000_0001);
                end
            end
            h_ready[0] = 1'b1;
            @(negedge clk);
            h_ready[0] = 1'b0;
        end
        wait_done(0, 100, "test_done_tmo");
        chk("test_accepts",  64'(n_acc[0] - ba), 64'd3);
        chk("test_advances", 64'(n_adv[0] - bv), 64'd2);
        chk("test_restarts", 64'(n_rst[0] - br), 64'd1);
        chk("test_starts",   64'(n_start[0] - bs), 64'd1);
        chk("test_ten_off",  64'(b_ten[0]), 64'd0);

        // Abort during RUN of region 2.
        pulse_start(0, 1'b0, 16'd0);
        n = 0;
        while (!(b_start[0] && b_region[0] == 16'd2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        got = b_start[0];
        chk("abort_reach_r2_tmo", 64'(got), 64'd1);
        repeat (3) @(negedge clk);
        h_abort[0] = 1'b1;
        @(negedge clk);
        h_abort[0] = 1'b0;
        chk("abort_restart", 64'(b_rst[0]), 64'd1);
        chk("abort_busy",    64'(h_busy[0]), 64'd0);
        chk("abort_done",    64'(h_done[0]), 64'd0);
        chk("abort_rdone",   64'(h_rdone[0]), 64'd2);
        chk("abort_total",   h_total[0], 64'd12);
        @(negedge clk);
        chk("abort_restart_pulse", 64'(b_rst[0]), 64'd0);
        pulse_start(0, 1'b0, 16'd0);
        wait_done(0, 300, "resweep_done_tmo");
        chk("resweep_total", h_total[0], 64'd32);

        // start together with abort in IDLE: start dropped.
        bs = n_start[0];
        @(negedge clk);
        h_start[0] = 1'b1; h_abort[0] = 1'b1;
        @(negedge clk);
        h_start[0] = 1'b0; h_abort[0] = 1'b0;
        chk("startabort_busy", 64'(h_busy[0]), 64'd0);
        chk("startabort_done", 64'(h_done[0]), 64'd1);
        repeat (3) @(negedge clk);
        chk("startabort_starts", 64'(n_start[0] - bs), 64'd0);

        // steps=0 behaves as one step.
        ba = n_acc[0]; bv = n_adv[0];
        h_ready[0] = 1'b1;
        pulse_start(0, 1'b1, 16'd0);
        wait_done(0, 100, "steps0_done_tmo");
        h_ready[0] = 1'b0;
        chk("steps0_accepts",  64'(n_acc[0] - ba), 64'd1);
        chk("steps0_advances", 64'(n_adv[0] - bv), 64'd0);

        // Asynchronous reset mid-sweep, checked before the next clock edge.
        pulse_start(0, 1'b0, 16'd0);
        n = 0;
        while (h_rdone[0] < 17'd1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("midsweep_progress", 64'(h_rdone[0]), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy",   64'(h_busy[0]), 64'd0);
        chk("arst_total",  h_total[0], 64'd0);
        chk("arst_rdone",  64'(h_rdone[0]), 64'd0);
        chk("arst_region", 64'(b_region[0]), 64'd0);
        chk("arst_done",   64'(h_done[0]), 64'd0);
        chk("arst_start",  64'(b_start[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
